// File: rtl/i2c_target.sv
// I2C target emulating the ADAU1761 control port: 7-bit device address, 16-bit
// register pointer, auto-incrementing byte reads/writes through a simple register port.

module i2c_target_filt #(
  parameter int LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Output follows the synchronized level only after it has differed for LEN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      dout <= 1'b1;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(LEN - 1)) begin
        dout <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module i2c_target #(
  parameter logic [6:0] C_CHIP_ADDRESS = 7'h38,
  parameter int         C_FILTER_LEN   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  output logic        busy,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata
);
  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, SUB_HI, ACK_HI, SUB_LO, ACK_LO,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  state_t     state;
  logic [1:0] raw, filt;
  logic       scl_f, sda_f, scl_q, sda_q;
  logic       start, stop, rise, fall;
  logic [2:0] cnt;
  logic [7:0] shreg, byte_in, hi_byte, tx;
  logic       rw, ack_on, re_q, sda_oe;

  assign raw = {scl, sda};
  for (genvar i = 0; i < 2; i++) begin : g_filt
    i2c_target_filt #(.LEN(C_FILTER_LEN)) u_filt (
      .clk (clk),
      .rst (rst),
      .din (raw[i]),
      .dout(filt[i])
    );
  end

  assign scl_f   = filt[1];
  assign sda_f   = filt[0];
  assign sda     = sda_oe ? 1'b0 : 1'bz;
  assign start   = scl_f & scl_q & sda_q & ~sda_f;
  assign stop    = scl_f & scl_q & ~sda_q & sda_f;
  assign rise    = scl_f & ~scl_q;
  assign fall    = ~scl_f & scl_q;
  assign byte_in = {shreg[6:0], sda_f};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;   scl_q  <= 1'b1;  sda_q  <= 1'b1;
      cnt   <= '0;     shreg  <= '0;    hi_byte <= '0;  tx <= '0;
      rw    <= 1'b0;   ack_on <= 1'b0;  re_q   <= 1'b0; sda_oe <= 1'b0;
      busy  <= 1'b0;   reg_addr <= '0;  reg_wdata <= '0;
      reg_we <= 1'b0;  reg_re <= 1'b0;
    end else begin
      scl_q  <= scl_f;
      sda_q  <= sda_f;
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      re_q   <= reg_re;
      if (reg_we) reg_addr <= reg_addr + 16'd1;

      // Bus conditions override any bit activity in the same cycle.
      if (start) begin
        state  <= DEV_ADDR;
        cnt    <= '0;
        sda_oe <= 1'b0;
        ack_on <= 1'b0;
        busy   <= 1'b1;
      end else if (stop) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          DEV_ADDR, SUB_HI, SUB_LO, WR_DATA: if (rise) begin
            shreg <= byte_in;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              ack_on <= 1'b0;
              case (state)
                DEV_ADDR: if (byte_in[7:1] == C_CHIP_ADDRESS) begin
                  state <= DEV_ACK;
                  rw    <= byte_in[0];
                end else begin
                  state <= IDLE;
                end
                SUB_HI: begin hi_byte <= byte_in; state <= ACK_HI; end
                SUB_LO: begin reg_addr <= {hi_byte, byte_in}; state <= ACK_LO; end
                default: begin reg_wdata <= byte_in; reg_we <= 1'b1; state <= WR_ACK; end
              endcase
            end
          end
          // First falling edge after the byte drives ACK, the next one releases it.
          DEV_ACK, ACK_HI, ACK_LO, WR_ACK: if (fall) begin
            if (!ack_on) begin
              sda_oe <= 1'b1;
              ack_on <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              ack_on <= 1'b0;
              cnt    <= '0;
              case (state)
                DEV_ACK: if (rw) begin state <= RD_DATA; reg_re <= 1'b1; end
                         else state <= SUB_HI;
                ACK_HI:  state <= SUB_LO;
                default: state <= WR_DATA;
              endcase
            end
          end
          RD_DATA: begin
            if (re_q) begin
              tx     <= reg_rdata;
              sda_oe <= ~reg_rdata[7];
            end else if (fall) begin
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                sda_oe <= 1'b0;
                ack_on <= 1'b0;
                state  <= RD_ACK;
              end else begin
                tx     <= {tx[6:0], 1'b0};
                sda_oe <= ~tx[6];
              end
            end
          end
          // ack_on here remembers that the master ACKed, so the next byte is fetched on fall.
          RD_ACK: begin
            if (rise) begin
              if (!sda_f) begin
                reg_addr <= reg_addr + 16'd1;
                ack_on   <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else if (fall && ack_on) begin
              state  <= RD_DATA;
              reg_re <= 1'b1;
              cnt    <= '0;
              ack_on <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged master, register-port scoreboard, optional glitch injection.

module tb_i2c_target;
  localparam int Q = 10;

  logic        clk = 1'b0, rst = 1'b1, scl = 1'b1, m_low = 1'b0, glitch_en = 1'b0;
  logic        busy, reg_we, reg_re, bit_rd;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata, reg_rdata = 8'h00;
  wire         sda;
  int          total = 0, bad = 0;
  int          we_n = 0, re_n = 0, both_n = 0;
  logic [15:0] we_a [64];
  logic [7:0]  we_d [64];
  logic [15:0] re_a [64];

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);
  always #5 clk = ~clk;

  i2c_target #(.C_CHIP_ADDRESS(7'h38), .C_FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .busy(busy),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .reg_rdata(reg_rdata)
  );

  function automatic logic [7:0] rd_model(input logic [15:0] a);
    case (a)
      16'h4015: return 8'h5A;
      16'h4016: return 8'hC3;
      default:  return a[7:0] ^ 8'h3C;
    endcase
  endfunction

  always @(posedge clk) if (reg_re) reg_rdata <= rd_model(reg_addr);

  always @(negedge clk) begin
    if (reg_we) begin we_a[we_n[5:0]] = reg_addr; we_d[we_n[5:0]] = reg_wdata; we_n++; end
    if (reg_re) begin re_a[re_n[5:0]] = reg_addr; re_n++; end
    if (reg_we && reg_re) both_n++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period; sda is set mid-low, sampled mid-high into bit_rd.
  task automatic clk_bit(input logic b);
    cyc(Q); m_low = ~b; cyc(Q/2);
    if (glitch_en) begin scl = 1'b1; cyc(1); scl = 1'b0; end
    cyc(Q/2); scl = 1'b1; cyc(Q/2);
    if (glitch_en) begin m_low = ~m_low; cyc(1); m_low = ~m_low; end
    cyc(Q/2); bit_rd = sda; cyc(Q/2); scl = 1'b0;
  endtask

  task automatic do_start();
    m_low = 1'b0; cyc(2*Q); scl = 1'b1; cyc(Q); m_low = 1'b1; cyc(Q); scl = 1'b0;
  endtask

  task automatic do_stop();
    cyc(Q); m_low = 1'b1; cyc(Q); scl = 1'b1; cyc(Q); m_low = 1'b0; cyc(2*Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) clk_bit(d[i]);
    clk_bit(1'b1);
    ack = bit_rd;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin clk_bit(1'b1); d[i] = bit_rd; end
    clk_bit(nack);
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(3);
    total++;
    if ({busy, sda, reg_we, reg_re} !== 4'b0100) begin
      bad++; $display("FAIL reset_flags got=%b want=0100", {busy, sda, reg_we, reg_re});
    end
    total++;
    if ({reg_addr, reg_wdata} !== 24'h0) begin
      bad++; $display("FAIL reset_regs got=%h want=000000", {reg_addr, reg_wdata});
    end
    rst = 1'b0; cyc(20);
  endtask

  task automatic test_write();
    logic [7:0] b [4] = '{8'h70, 8'h40, 8'h00, 8'hA5};
    logic a; int w0 = we_n;
    do_start();
    for (int i = 0; i < 4; i++) begin
      wr_byte(b[i], a);
      total++; if (a !== 1'b0) begin bad++; $display("FAIL wr_ack%0d got=%b want=0", i, a); end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b want=1", busy); end
    do_stop();
    total++; if (we_n - w0 !== 1) begin bad++; $display("FAIL wr_count got=%0d want=1", we_n - w0); end
    total++; if (we_a[w0[5:0]] !== 16'h4000) begin bad++; $display("FAIL wr_addr got=%h want=4000", we_a[w0[5:0]]); end
    total++; if (we_d[w0[5:0]] !== 8'hA5) begin bad++; $display("FAIL wr_data got=%h want=a5", we_d[w0[5:0]]); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_p got=%b want=0", busy); end
  endtask

  task automatic test_wrap();
    logic [7:0] b [5] = '{8'h70, 8'hFF, 8'hFF, 8'h11, 8'h22};
    logic a; int w0 = we_n; int w1 = we_n + 1;
    do_start();
    for (int i = 0; i < 5; i++) begin
      wr_byte(b[i], a);
      total++; if (a !== 1'b0) begin bad++; $display("FAIL wrap_ack%0d got=%b want=0", i, a); end
    end
    do_stop();
    total++; if (we_n - w0 !== 2) begin bad++; $display("FAIL wrap_count got=%0d want=2", we_n - w0); end
    total++; if ({we_a[w0[5:0]], we_d[w0[5:0]]} !== 24'hFFFF11) begin
      bad++; $display("FAIL wrap_first got=%h want=ffff11", {we_a[w0[5:0]], we_d[w0[5:0]]}); end
    total++; if ({we_a[w1[5:0]], we_d[w1[5:0]]} !== 24'h000022) begin
      bad++; $display("FAIL wrap_second got=%h want=000022", {we_a[w1[5:0]], we_d[w1[5:0]]}); end
  endtask

  task automatic test_read();
    logic [7:0] b [3] = '{8'h70, 8'h40, 8'h15};
    logic [7:0] d0, d1; logic a; int r0 = re_n; int r1 = re_n + 1; int w0 = we_n;
    do_start();
    for (int i = 0; i < 3; i++) begin
      wr_byte(b[i], a);
      total++; if (a !== 1'b0) begin bad++; $display("FAIL rd_ack%0d got=%b want=0", i, a); end
    end
    do_start();
    wr_byte(8'h71, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL rd_devack got=%b want=0", a); end
    rd_byte(1'b0, d0);
    rd_byte(1'b1, d1);
    do_stop();
    total++; if (d0 !== 8'h5A) begin bad++; $display("FAIL rd_byte0 got=%b want=01011010", d0); end
    total++; if (d1 !== 8'hC3) begin bad++; $display("FAIL rd_byte1 got=%b want=11000011", d1); end
    total++; if (re_n - r0 !== 2) begin bad++; $display("FAIL rd_count got=%0d want=2", re_n - r0); end
    total++; if (re_a[r0[5:0]] !== 16'h4015) begin bad++; $display("FAIL rd_addr0 got=%h want=4015", re_a[r0[5:0]]); end
    total++; if (re_a[r1[5:0]] !== 16'h4016) begin bad++; $display("FAIL rd_addr1 got=%h want=4016", re_a[r1[5:0]]); end
    total++; if (we_n !== w0) begin bad++; $display("FAIL rd_nowe got=%0d want=0", we_n - w0); end
  endtask

  task automatic test_nomatch();
    logic [7:0] b [3] = '{8'h72, 8'h40, 8'h00};
    logic a; int w0 = we_n; int r0 = re_n;
    do_start();
    for (int i = 0; i < 3; i++) begin
      wr_byte(b[i], a);
      total++; if (a !== 1'b1) begin bad++; $display("FAIL nm_ack%0d got=%b want=1", i, a); end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL nm_busy got=%b want=1", busy); end
    do_stop();
    total++; if ((we_n - w0) + (re_n - r0) !== 0) begin
      bad++; $display("FAIL nm_strobes got=%0d want=0", (we_n - w0) + (re_n - r0)); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL nm_busy_p got=%b want=0", busy); end
  endtask

  task automatic test_partial();
    logic [7:0] b [3] = '{8'h70, 8'h40, 8'h00};
    logic a; int w0 = we_n;
    do_start();
    for (int i = 0; i < 3; i++) begin
      wr_byte(b[i], a);
      total++; if (a !== 1'b0) begin bad++; $display("FAIL pt_ack%0d got=%b want=0", i, a); end
    end
    clk_bit(1'b1); clk_bit(1'b0); clk_bit(1'b1); clk_bit(1'b1);
    do_stop();
    total++; if (we_n !== w0) begin bad++; $display("FAIL pt_nowe got=%0d want=0", we_n - w0); end
    total++; if ({busy, sda} !== 2'b01) begin bad++; $display("FAIL pt_idle got=%b want=01", {busy, sda}); end
    total++; if (reg_addr !== 16'h4000) begin bad++; $display("FAIL pt_ptr got=%h want=4000", reg_addr); end
  endtask

  // Pointer is 0x4000 here, so the first read byte is 0x3C and its MSB drives sda low.
  task automatic test_rst_mid();
    logic [7:0] d; logic a; int w0 = we_n; int r0 = re_n;
    do_start();
    wr_byte(8'h71, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL rm_ack got=%b want=0", a); end
    cyc(12);
    total++; if (sda !== 1'b0) begin bad++; $display("FAIL rm_drive got=%b want=0", sda); end
    rst = 1'b1; cyc(1);
    total++; if ({busy, sda} !== 2'b01) begin bad++; $display("FAIL rm_release got=%b want=01", {busy, sda}); end
    total++; if (reg_addr !== 16'h0) begin bad++; $display("FAIL rm_ptr got=%h want=0000", reg_addr); end
    rst = 1'b0;
    rd_byte(1'b1, d);
    total++; if (d !== 8'hFF) begin bad++; $display("FAIL rm_idle got=%h want=ff", d); end
    do_stop();
    total++; if (re_n - r0 !== 1) begin bad++; $display("FAIL rm_re got=%0d want=1", re_n - r0); end
    total++; if (we_n !== w0) begin bad++; $display("FAIL rm_nowe got=%0d want=0", we_n - w0); end
  endtask

  task automatic test_strobes();
    total++; if (both_n !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d want=0", both_n); end
  endtask

  initial begin
    test_reset();
    for (int g = 0; g < 2; g++) begin
      glitch_en = (g == 1);
      test_write();
      test_wrap();
      test_read();
      test_nomatch();
      test_partial();
      test_rst_mid();
    end
    test_strobes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
